// File: rtl/obj_fetch_sequencer_if.sv
// VRAM read port and pixel-word stream between the OBJ fetch sequencer and its neighbours.
// The sequencer is the master: it requests VRAM reads and sources pixel words.
interface obj_fetch_sequencer_if #(
  parameter int unsigned VRAM_AW = 15,
  parameter int unsigned DW      = 32
);
  logic               vram_req;
  logic [VRAM_AW-1:0] vram_addr;
  logic               vram_ack;
  logic [DW-1:0]      vram_rdata;

  logic               pix_valid;
  logic [DW-1:0]      pix_data;
  logic               pix_first;
  logic               pix_ready;

  modport master (
    output vram_req, vram_addr, pix_valid, pix_data, pix_first,
    input  vram_ack, vram_rdata, pix_ready
  );

  modport slave (
    input  vram_req, vram_addr, pix_valid, pix_data, pix_first,
    output vram_ack, vram_rdata, pix_ready
  );
endinterface

// File: rtl/obj_fetch_sequencer.sv
// Per-sprite, per-scanline VRAM fetch sequencer: walks one sprite row a 32-bit word at a
// time through the OBJ address unit, reads VRAM and hands each word to the line renderer.
module obj_fetch_sequencer #(
  parameter int unsigned VRAM_AW = 15,
  parameter int unsigned DW      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [9:0]         obj_name,
  input  logic               palettemode,
  input  logic               oam_mode,
  input  logic [6:0]         width_px,
  input  logic [6:0]         height_px,
  input  logic [5:0]         row,
  input  logic               hflip,
  input  logic               vflip,
  output logic [9:0]         au_objname,
  output logic               au_palettemode,
  output logic               au_oam_mode,
  output logic [5:0]         au_x,
  output logic [5:0]         au_y,
  output logic [6:0]         au_hsize,
  input  logic [VRAM_AW-1:0] au_addr,
  obj_fetch_sequencer_if.master bus,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {StIdle, StAddr, StReq, StOut, StDone} state_e;

  state_e             state_q, state_d;
  logic [4:0]         word_cnt_q, word_cnt_d;
  logic [4:0]         last_q, last_d;
  logic [9:0]         name_q, name_d;
  logic               pal_q, pal_d;
  logic               oam_q, oam_d;
  logic [6:0]         width_q, width_d;
  logic [5:0]         y_q, y_d;
  logic               hflip_q, hflip_d;
  logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
  logic [DW-1:0]      pix_data_q, pix_data_d;

  logic [4:0] nwords;
  logic [5:0] step, x_fwd, x_rev;

  // Widths below one word (including 0) fall back to an 8-pixel row so the FSM terminates.
  always_comb begin
    nwords = palettemode ? width_px[6:2] : {1'b0, width_px[6:3]};
    if (nwords == 5'd0) begin
      nwords = palettemode ? 5'd2 : 5'd1;
    end
  end

  always_comb begin
    step  = pal_q ? 6'd4 : 6'd8;
    x_fwd = pal_q ? {word_cnt_q[3:0], 2'b00} : {word_cnt_q[2:0], 3'b000};
    x_rev = width_q[5:0] - step - x_fwd;
  end

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    last_d      = last_q;
    name_d      = name_q;
    pal_d       = pal_q;
    oam_d       = oam_q;
    width_d     = width_q;
    y_d         = y_q;
    hflip_d     = hflip_q;
    vram_addr_d = vram_addr_q;
    pix_data_d  = pix_data_q;

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            name_d     = obj_name;
            pal_d      = palettemode;
            oam_d      = oam_mode;
            width_d    = width_px;
            // Only the low 6 bits of the flipped line matter, so 6-bit wraparound is exact.
            y_d        = vflip ? (height_px[5:0] - 6'd1 - row) : row;
            hflip_d    = hflip;
            last_d     = nwords - 5'd1;
            word_cnt_d = 5'd0;
            state_d    = StAddr;
          end
        end
        StAddr: begin
          vram_addr_d = {au_addr[VRAM_AW-1:2], 2'b00};
          state_d     = StReq;
        end
        StReq: begin
          if (bus.vram_ack) begin
            pix_data_d = bus.vram_rdata;
            state_d    = StOut;
          end
        end
        StOut: begin
          if (bus.pix_ready) begin
            if (word_cnt_q == last_q) begin
              state_d = StDone;
            end else begin
              word_cnt_d = word_cnt_q + 5'd1;
              state_d    = StAddr;
            end
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      word_cnt_q  <= '0;
      last_q      <= '0;
      name_q      <= '0;
      pal_q       <= 1'b0;
      oam_q       <= 1'b0;
      width_q     <= '0;
      y_q         <= '0;
      hflip_q     <= 1'b0;
      vram_addr_q <= '0;
      pix_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      last_q      <= last_d;
      name_q      <= name_d;
      pal_q       <= pal_d;
      oam_q       <= oam_d;
      width_q     <= width_d;
      y_q         <= y_d;
      hflip_q     <= hflip_d;
      vram_addr_q <= vram_addr_d;
      pix_data_q  <= pix_data_d;
    end
  end

  always_comb begin
    au_objname     = name_q;
    au_palettemode = pal_q;
    au_oam_mode    = oam_q;
    au_x           = hflip_q ? x_rev : x_fwd;
    au_y           = y_q;
    au_hsize       = width_q;
    bus.vram_req   = (state_q == StReq);
    bus.vram_addr  = vram_addr_q;
    bus.pix_valid  = (state_q == StOut);
    bus.pix_data   = pix_data_q;
    bus.pix_first  = (state_q == StOut) && (word_cnt_q == 5'd0);
    busy           = (state_q != StIdle);
    done           = (state_q == StDone);
  end

endmodule

// File: tb/tb_obj_fetch_sequencer.sv
// Bench for obj_fetch_sequencer: table of sprite-row descriptors with a VRAM/renderer
// responder and a queue of expected pixel words, plus abort and reset sequences.
module tb_obj_fetch_sequencer;
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [9:0]    obj_name = '0;
  logic          palettemode = 1'b0;
  logic          oam_mode = 1'b0;
  logic [6:0]    width_px = '0;
  logic [6:0]    height_px = '0;
  logic [5:0]    row = '0;
  logic          hflip = 1'b0;
  logic          vflip = 1'b0;
  logic [9:0]    au_objname;
  logic          au_palettemode;
  logic          au_oam_mode;
  logic [5:0]    au_x;
  logic [5:0]    au_y;
  logic [6:0]    au_hsize;
  logic [AW-1:0] au_addr;
  logic          busy;
  logic          done;

  obj_fetch_sequencer_if #(.VRAM_AW(AW), .DW(DW)) bus ();

  obj_fetch_sequencer #(.VRAM_AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .obj_name       (obj_name),
    .palettemode    (palettemode),
    .oam_mode       (oam_mode),
    .width_px       (width_px),
    .height_px      (height_px),
    .row            (row),
    .hflip          (hflip),
    .vflip          (vflip),
    .au_objname     (au_objname),
    .au_palettemode (au_palettemode),
    .au_oam_mode    (au_oam_mode),
    .au_x           (au_x),
    .au_y           (au_y),
    .au_hsize       (au_hsize),
    .au_addr        (au_addr),
    .bus            (bus.master),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Stand-in address unit; low bits come from the tile number so they are often unaligned.
  assign au_addr = {au_y, au_x, 3'b000} ^ {5'b0, au_objname};

  typedef struct {
    logic       pal;
    logic       oam;
    logic [6:0] width;
    logic [6:0] height;
    logic [5:0] row;
    logic       hf;
    logic       vf;
    logic [9:0] name;
    int         ack_dly;
    int         rdy_dly;
    int         abort_word;
    bit         noisy;
    int         exp_words;
    int         exp_y;
    int         exp_x0;
    int         exp_xstep;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          idx;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   bus.vram_req, 0);
    check({tag, "_addr"},  bus.vram_addr, 0);
    check({tag, "_valid"}, bus.pix_valid, 0);
    check({tag, "_data"},  bus.pix_data, 0);
    check({tag, "_first"}, bus.pix_first, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_au"},    {au_objname, au_palettemode, au_oam_mode, au_x, au_y, au_hsize}, 0);
  endtask

  task automatic run_row(input vec_t v);
    int            cyc;
    int            widx;
    int            req_wait;
    int            out_wait;
    int            words;
    bit            seen_done;
    logic [AW-1:0] addr0;
    logic [AW-1:0] exp_a;
    logic [5:0]    exp_x;
    logic [5:0]    exp_y;
    logic [31:0]   rd;
    exp_t          e;

    sb.delete();
    @(negedge clk);
    palettemode = v.pal; oam_mode = v.oam; width_px = v.width; height_px = v.height;
    row = v.row; hflip = v.hf; vflip = v.vf; obj_name = v.name; start = 1'b1;
    @(negedge clk);
    cyc = 1;
    if (v.noisy) begin
      // Keep start high and scramble the descriptor; none of it may leak into this row.
      palettemode = ~v.pal; width_px = 7'd64; height_px = 7'd8; row = 6'd1;
      hflip = ~v.hf; vflip = ~v.vf; obj_name = ~v.name;
    end else begin
      start = 1'b0;
    end
    widx = 0; req_wait = 0; out_wait = 0; words = 0; seen_done = 0;
    exp_y = 6'(v.exp_y);
    while (cyc < 400) begin
      bus.vram_ack  = 1'b0;
      bus.pix_ready = 1'b0;
      if (done) begin
        seen_done = 1;
        break;
      end
      if (bus.vram_req) begin
        if (req_wait == 0) begin
          exp_x = 6'(v.exp_x0 + widx * v.exp_xstep);
          exp_a = ({exp_y, exp_x, 3'b000} ^ {5'b0, v.name}) & ~15'd3;
          check("au_x", au_x, exp_x);
          check("au_y", au_y, exp_y);
          check("vram_addr", bus.vram_addr, exp_a);
          addr0 = bus.vram_addr;
          if (widx == 0) begin
            check("au_hsize", au_hsize, v.width);
            check("au_objname", au_objname, v.name);
            check("au_modes", {au_palettemode, au_oam_mode}, {v.pal, v.oam});
          end
        end else begin
          check("vram_addr_hold", bus.vram_addr, addr0);
        end
        if (req_wait >= v.ack_dly) begin
          rd = $urandom;
          bus.vram_ack   = 1'b1;
          bus.vram_rdata = rd;
          if (widx == v.abort_word) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            bus.vram_ack = 1'b0;
            check("abort_req", bus.vram_req, 0);
            check("abort_valid", bus.pix_valid, 0);
            check("abort_busy", busy, 0);
            for (int k = 0; k < 3; k++) begin
              @(negedge clk);
              check("abort_no_done", {done, busy}, 0);
            end
            return;
          end
          e.data = rd;
          e.idx  = widx;
          sb.push_back(e);
          widx++;
          req_wait = 0;
        end else begin
          req_wait++;
        end
      end
      if (bus.pix_valid) begin
        if (sb.size() == 0) begin
          check("pix_unexpected", 1, 0);
        end else begin
          check("pix_data", bus.pix_data, sb[0].data);
          check("pix_first", bus.pix_first, sb[0].idx == 0);
          if (out_wait >= v.rdy_dly) begin
            bus.pix_ready = 1'b1;
            void'(sb.pop_front());
            words++;
            out_wait = 0;
          end else begin
            out_wait++;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.vram_ack  = 1'b0;
    bus.pix_ready = 1'b0;
    check("done_seen", seen_done, 1);
    check("words", words, v.exp_words);
    check("sb_empty", sb.size(), 0);
    if (v.ack_dly == 0 && v.rdy_dly == 0) check("done_cycle", cyc, 3 * v.exp_words + 1);
    @(negedge clk);
    check("idle_after_done", {busy, done}, 0);
    start = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    //          pal   oam   width  height row   hf    vf    name     ackd rdyd abw nz  N  y   x0  dx
    vecs[0] = '{1'b0, 1'b1, 7'd16, 7'd16, 6'd3, 1'b0, 1'b0, 10'h123, 0, 0, -1, 0, 2, 3, 0, 8};
    vecs[1] = '{1'b1, 1'b0, 7'd32, 7'd32, 6'd7, 1'b1, 1'b0, 10'h05a, 0, 0, -1, 0, 8, 7, 28, -4};
    vecs[2] = '{1'b0, 1'b1, 7'd8, 7'd64, 6'd5, 1'b0, 1'b1, 10'h3ff, 0, 0, -1, 0, 1, 58, 0, 8};
    vecs[3] = '{1'b0, 1'b0, 7'd64, 7'd32, 6'd10, 1'b1, 1'b1, 10'h2c7, 4, 3, -1, 0, 8, 21, 56, -8};
    vecs[4] = '{1'b1, 1'b1, 7'd16, 7'd8, 6'd2, 1'b0, 1'b0, 10'h0f1, 0, 0, -1, 1, 4, 2, 0, 4};
    vecs[5] = '{1'b1, 1'b0, 7'd32, 7'd16, 6'd1, 1'b0, 1'b0, 10'h111, 0, 0, 2, 0, 8, 1, 0, 4};
    vecs[6] = '{1'b0, 1'b0, 7'd32, 7'd8, 6'd0, 1'b0, 1'b1, 10'h201, 0, 0, -1, 0, 4, 7, 0, 8};
    vecs[7] = '{1'b0, 1'b0, 7'd0, 7'd8, 6'd0, 1'b0, 1'b0, 10'h033, 0, 0, -1, 0, 1, 0, 0, 8};
    vecs[8] = '{1'b1, 1'b1, 7'd0, 7'd16, 6'd15, 1'b1, 1'b0, 10'h155, 1, 2, -1, 0, 2, 15, 60, -4};

    bus.vram_ack   = 1'b0;
    bus.vram_rdata = '0;
    bus.pix_ready  = 1'b0;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_row(vecs[i]);

    // abort+start together in IDLE: abort wins
    @(negedge clk);
    obj_name = 10'h2ab; width_px = 7'd32; palettemode = 1'b0; hflip = 1'b1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", busy, 0);

    // Asynchronous reset while a word is waiting in OUT
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10 && !bus.vram_req; k++) @(negedge clk);
    check("rst_seq_req", bus.vram_req, 1);
    bus.vram_ack = 1'b1; bus.vram_rdata = 32'hdeadbeef;
    @(negedge clk);
    bus.vram_ack = 1'b0;
    check("rst_seq_valid", bus.pix_valid, 1);
    check("rst_seq_data", bus.pix_data, 32'hdeadbeef);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
